// File: rtl/pid_core_mc.sv
// Time-multiplexed multi-channel PID core with one shared multiplier.
// Per-channel gains, integrator with anti-windup, and saturated duty output.
module pid_core_mc #(
   parameter int NCH  = 4,
   parameter int W    = 14,
   parameter int KW   = 10,
   parameter int IW   = 18,
   parameter int FRAC = 6,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           meas_vld,
   input  logic [CHW-1:0] meas_ch,
   input  logic [W-1:0]   meas,
   output logic           meas_rdy,
   input  logic           cfg_wr,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [1:0]     cfg_sel,
   input  logic [W-1:0]   cfg_data,
   input  logic           clr_int,
   output logic           duty_vld,
   output logic [CHW-1:0] duty_ch,
   output logic [W-1:0]   duty,
   output logic           busy
);

   localparam int AW = W + KW + 3;
   localparam int PW = W + KW + 1;
   localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};
   localparam logic [IW-1:0] MAXI = {1'b0, {(IW-1){1'b1}}};
   localparam logic [IW-1:0] MINI = {1'b1, {(IW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_PT, S_IT, S_DT, S_OUT
   } state_t;

   state_t state_q;

   logic [W-1:0]  sp_q    [NCH];
   logic [KW-1:0] kp_q    [NCH];
   logic [KW-1:0] ki_q    [NCH];
   logic [KW-1:0] kd_q    [NCH];
   logic [IW-1:0] integ_q [NCH];
   logic [W-1:0]  perr_q  [NCH];
   logic [NCH-1:0] satp_q, satn_q;

   logic [CHW-1:0] ch_q;
   logic [W-1:0]   s_meas_q, s_sp_q;
   logic [KW-1:0]  s_kp_q, s_ki_q, s_kd_q;
   logic [W-1:0]   err_q, diff_q;
   logic [AW-1:0]  acc_q;
   logic           duty_vld_q;
   logic [CHW-1:0] duty_ch_q;
   logic [W-1:0]   duty_q;

   logic [W:0]    e_full, d_full;
   logic [W-1:0]  err_d, diff_d;
   logic [IW:0]   i_full;
   logic [IW-1:0] integ_d;
   logic          hold;

   always_comb begin
      e_full = {s_sp_q[W-1], s_sp_q} - {s_meas_q[W-1], s_meas_q};
      if (e_full[W] != e_full[W-1]) err_d = e_full[W] ? MINW : MAXW;
      else                          err_d = e_full[W-1:0];
      d_full = {err_d[W-1], err_d} - {perr_q[ch_q][W-1], perr_q[ch_q]};
      if (d_full[W] != d_full[W-1]) diff_d = d_full[W] ? MINW : MAXW;
      else                          diff_d = d_full[W-1:0];
      i_full = {integ_q[ch_q][IW-1], integ_q[ch_q]}
             + {{(IW+1-W){err_d[W-1]}}, err_d};
      if (i_full[IW] != i_full[IW-1]) integ_d = i_full[IW] ? MINI : MAXI;
      else                            integ_d = i_full[IW-1:0];
      // Freeze the integrator while it would push further into a clip
      hold = (satp_q[ch_q] && !err_d[W-1] && (err_d != '0))
          || (satn_q[ch_q] && err_d[W-1]);
   end

   logic [W-1:0]         mul_a;
   logic [KW-1:0]        mul_b;
   logic signed [PW-1:0] mul_ax, mul_bx, prod, term;
   logic [AW-1:0]        term_x, acc_sum;
   logic [W-1:0]         duty_d;
   logic                 fits, clip_p, clip_n;

   always_comb begin
      case (state_q)
         S_IT: begin
            mul_a = integ_q[ch_q][IW-1 -: W];
            mul_b = s_ki_q;
         end
         S_DT: begin
            mul_a = diff_q;
            mul_b = s_kd_q;
         end
         default: begin
            mul_a = err_q;
            mul_b = s_kp_q;
         end
      endcase
      mul_ax  = {{(PW-W){mul_a[W-1]}}, mul_a};
      mul_bx  = {{(PW-KW){1'b0}}, mul_b};
      prod    = mul_ax * mul_bx;
      term    = prod >>> FRAC;
      term_x  = {{(AW-PW){term[PW-1]}}, term};
      acc_sum = acc_q + term_x;
      fits    = (&acc_sum[AW-1:W-1]) || (~|acc_sum[AW-1:W-1]);
      clip_p  = !fits && !acc_sum[AW-1];
      clip_n  = !fits && acc_sum[AW-1];
      if (clip_p)      duty_d = MAXW;
      else if (clip_n) duty_d = MINW;
      else             duty_d = acc_sum[W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         s_meas_q   <= '0;
         s_sp_q     <= '0;
         s_kp_q     <= '0;
         s_ki_q     <= '0;
         s_kd_q     <= '0;
         err_q      <= '0;
         diff_q     <= '0;
         acc_q      <= '0;
         duty_vld_q <= 1'b0;
         duty_ch_q  <= '0;
         duty_q     <= '0;
         satp_q     <= '0;
         satn_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            sp_q[i]    <= '0;
            kp_q[i]    <= '0;
            ki_q[i]    <= '0;
            kd_q[i]    <= '0;
            integ_q[i] <= '0;
            perr_q[i]  <= '0;
         end
      end else begin
         duty_vld_q <= 1'b0;
         if (cfg_wr && (int'(cfg_ch) < NCH)) begin
            case (cfg_sel)
               2'd0:    sp_q[cfg_ch] <= cfg_data;
               2'd1:    kp_q[cfg_ch] <= cfg_data[KW-1:0];
               2'd2:    ki_q[cfg_ch] <= cfg_data[KW-1:0];
               default: kd_q[cfg_ch] <= cfg_data[KW-1:0];
            endcase
         end
         case (state_q)
            S_IDLE: begin
               // Out-of-range channels are consumed without a result
               if (meas_vld && (int'(meas_ch) < NCH)) begin
                  ch_q     <= meas_ch;
                  s_meas_q <= meas;
                  s_sp_q   <= sp_q[meas_ch];
                  s_kp_q   <= kp_q[meas_ch];
                  s_ki_q   <= ki_q[meas_ch];
                  s_kd_q   <= kd_q[meas_ch];
                  state_q  <= S_ERR;
               end
            end
            S_ERR: begin
               err_q        <= err_d;
               diff_q       <= diff_d;
               perr_q[ch_q] <= err_d;
               if (!hold) integ_q[ch_q] <= integ_d;
               state_q <= S_PT;
            end
            S_PT: begin
               acc_q   <= term_x;
               state_q <= S_IT;
            end
            S_IT: begin
               acc_q   <= acc_sum;
               state_q <= S_DT;
            end
            S_DT: begin
               acc_q        <= acc_sum;
               duty_q       <= duty_d;
               duty_ch_q    <= ch_q;
               duty_vld_q   <= 1'b1;
               satp_q[ch_q] <= clip_p;
               satn_q[ch_q] <= clip_n;
               state_q      <= S_OUT;
            end
            default: state_q <= S_IDLE;
         endcase
         if (clr_int) begin
            satp_q <= '0;
            satn_q <= '0;
            for (int i = 0; i < NCH; i++) begin
               integ_q[i] <= '0;
               perr_q[i]  <= '0;
            end
         end
      end
   end

   assign meas_rdy = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign duty_vld = duty_vld_q;
   assign duty_ch  = duty_ch_q;
   assign duty     = duty_q;

endmodule

// File: tb/tb_pid_core_mc.sv
// Bench for pid_core_mc: directed table, corner sequences, and a
// randomized run against an arithmetic per-channel PID model.
module tb_pid_core_mc;

   localparam int NCH = 4;
   localparam int W = 14;
   localparam int KW = 10;
   localparam int IW = 18;
   localparam int FRAC = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic meas_vld = 1'b0;
   logic [1:0] meas_ch = '0;
   logic [W-1:0] meas = '0;
   logic meas_rdy;
   logic cfg_wr = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [1:0] cfg_sel = '0;
   logic [W-1:0] cfg_data = '0;
   logic clr_int = 1'b0;
   logic duty_vld;
   logic [1:0] duty_ch;
   logic [W-1:0] duty;
   logic busy;

   logic meas_vld3 = 1'b0;
   logic [1:0] meas_ch3 = '0;
   logic [W-1:0] meas3 = '0;
   logic meas_rdy3, duty_vld3, busy3;
   logic [1:0] duty_ch3;
   logic [W-1:0] duty3;

   always #5 clk = ~clk;

   pid_core_mc #(.NCH(NCH), .W(W), .KW(KW), .IW(IW), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst),
      .meas_vld(meas_vld), .meas_ch(meas_ch), .meas(meas),
      .meas_rdy(meas_rdy),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .clr_int(clr_int),
      .duty_vld(duty_vld), .duty_ch(duty_ch), .duty(duty),
      .busy(busy)
   );

   pid_core_mc #(.NCH(3), .W(W), .KW(KW), .IW(IW), .FRAC(FRAC)) dut3 (
      .clk(clk), .rst(rst),
      .meas_vld(meas_vld3), .meas_ch(meas_ch3), .meas(meas3),
      .meas_rdy(meas_rdy3),
      .cfg_wr(1'b0), .cfg_ch(2'd0), .cfg_sel(2'd0),
      .cfg_data('0), .clr_int(1'b0),
      .duty_vld(duty_vld3), .duty_ch(duty_ch3), .duty(duty3),
      .busy(busy3)
   );

   int checks = 0;
   int errors = 0;

   int m_sp[NCH], m_kp[NCH], m_ki[NCH], m_kd[NCH];
   longint m_int[NCH];
   int m_perr[NCH], m_sat[NCH];

   typedef struct {
      bit clr;
      int ch, sp, kp, ki, kd, meas, exp;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clamp(input longint v, input int bits);
      longint hi, lo;
      hi = (longint'(1) <<< (bits - 1)) - 1;
      lo = -hi - 1;
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   function automatic void model_reset(input bit all);
      for (int i = 0; i < NCH; i++) begin
         m_int[i] = 0;
         m_perr[i] = 0;
         m_sat[i] = 0;
         if (all) begin
            m_sp[i] = 0; m_kp[i] = 0; m_ki[i] = 0; m_kd[i] = 0;
         end
      end
   endfunction

   function automatic int model_step(input int ch, input int mv);
      longint err, dif, acc;
      err = clamp(longint'(m_sp[ch]) - mv, W);
      dif = clamp(err - m_perr[ch], W);
      if (!((m_sat[ch] == 1 && err > 0) || (m_sat[ch] == -1 && err < 0)))
         m_int[ch] = clamp(m_int[ch] + err, IW);
      m_perr[ch] = int'(err);
      acc = ((err * m_kp[ch]) >>> FRAC)
          + (((m_int[ch] >>> (IW - W)) * m_ki[ch]) >>> FRAC)
          + ((dif * m_kd[ch]) >>> FRAC);
      m_sat[ch] = (acc > 8191) ? 1 : (acc < -8192) ? -1 : 0;
      return int'(clamp(acc, W));
   endfunction

   task automatic cfg(input int ch, input int sel, input int data);
      cfg_wr = 1'b1;
      cfg_ch = 2'(ch);
      cfg_sel = 2'(sel);
      cfg_data = W'(data);
      tick();
      cfg_wr = 1'b0;
      case (sel)
         0: m_sp[ch] = data;
         1: m_kp[ch] = data;
         2: m_ki[ch] = data;
         default: m_kd[ch] = data;
      endcase
   endtask

   task automatic cfg_all(input int ch, input int sp, input int kp,
                          input int ki, input int kd);
      cfg(ch, 0, sp);
      cfg(ch, 1, kp);
      cfg(ch, 2, ki);
      cfg(ch, 3, kd);
   endtask

   task automatic pulse_clr();
      clr_int = 1'b1;
      tick();
      clr_int = 1'b0;
      model_reset(1'b0);
   endtask

   task automatic run_sample(input string nm, input int ch, input int mv,
                             input bit use_model, input int exp_c);
      int md, lat, e;
      bit rdy_ok;
      md = model_step(ch, mv);
      e = use_model ? md : exp_c;
      meas_vld = 1'b1;
      meas_ch = 2'(ch);
      meas = W'(mv);
      tick();
      meas_vld = 1'b0;
      lat = 1;
      rdy_ok = 1'b1;
      while (!duty_vld && lat < 12) begin
         if (meas_rdy || !busy) rdy_ok = 1'b0;
         tick();
         lat++;
      end
      if (meas_rdy || !busy) rdy_ok = 1'b0;
      chk({nm, "_lat"}, lat, 5);
      chk({nm, "_duty"}, longint'($signed(duty)), e);
      chk({nm, "_ch"}, duty_ch, ch);
      chk({nm, "_busy"}, rdy_ok, 1);
      tick();
      chk({nm, "_pulse"}, duty_vld, 0);
      chk({nm, "_hold"}, longint'($signed(duty)), e);
   endtask

   initial begin
      int exp_a, exp_b, nres, c0, c1;
      int lat;
      tbl[0] = '{0, 1, 1000, 64, 0, 0, 600, 400};
      tbl[1] = '{0, 0, 8191, 1023, 0, 0, -8192, 8191};
      tbl[2] = '{0, 0, 8191, 1023, 64, 0, -8192, 8191};
      tbl[3] = '{0, 0, 8191, 0, 64, 0, 8191, 511};
      tbl[4] = '{0, 2, 160, 0, 64, 0, 0, 10};
      tbl[5] = '{0, 2, 160, 0, 64, 0, 0, 20};
      tbl[6] = '{0, 2, 160, 0, 64, 0, 0, 30};
      tbl[7] = '{1, 2, 400, 0, 0, 64, 0, 400};
      tbl[8] = '{0, 2, 400, 0, 0, 64, 0, 0};
      tbl[9] = '{0, 2, 200, 0, 0, 64, 0, -200};
      model_reset(1'b1);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_vld", duty_vld, 0);
      chk("rst_duty", duty, 0);
      chk("rst_ch", duty_ch, 0);
      chk("rst_rdy", meas_rdy, 1);
      chk("rst_busy", busy, 0);
      tick();

      foreach (tbl[i]) begin
         if (tbl[i].clr) pulse_clr();
         cfg_all(tbl[i].ch, tbl[i].sp, tbl[i].kp, tbl[i].ki, tbl[i].kd);
         run_sample($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].meas,
                    1'b0, tbl[i].exp);
      end

      pulse_clr();
      cfg_all(0, 160, 0, 64, 0);
      cfg_all(3, 320, 0, 64, 0);
      run_sample("iso0a", 0, 0, 1'b0, 10);
      run_sample("iso3a", 3, 0, 1'b0, 20);
      run_sample("iso0b", 0, 0, 1'b0, 20);
      run_sample("iso3b", 3, 0, 1'b0, 40);
      pulse_clr();
      run_sample("clr0", 0, 0, 1'b0, 10);

      cfg_all(3, 500, 64, 0, 0);
      exp_a = model_step(3, 0);
      meas_vld = 1'b1;
      meas_ch = 2'd3;
      meas = '0;
      tick();
      meas_vld = 1'b0;
      tick();
      cfg_wr = 1'b1;
      cfg_ch = 2'd3;
      cfg_sel = 2'd1;
      cfg_data = W'(128);
      tick();
      cfg_wr = 1'b0;
      m_kp[3] = 128;
      lat = 3;
      while (!duty_vld && lat < 12) begin
         tick();
         lat++;
      end
      chk("cfgpt_lat", lat, 5);
      chk("cfgpt_duty", longint'($signed(duty)), 500);
      chk("cfgpt_model", exp_a, 500);
      tick();
      run_sample("cfgpt_next", 3, 0, 1'b0, 1000);

      exp_a = model_step(3, 100);
      exp_b = model_step(3, 100);
      nres = 0;
      c0 = -1;
      c1 = -1;
      meas_vld = 1'b1;
      meas_ch = 2'd3;
      meas = W'(100);
      for (int c = 0; c < 12; c++) begin
         if (duty_vld) begin
            if (nres == 0) begin
               c0 = c;
               chk("hs_duty0", longint'($signed(duty)), exp_a);
            end else begin
               c1 = c;
               chk("hs_duty1", longint'($signed(duty)), exp_b);
            end
            nres++;
         end
         tick();
      end
      meas_vld = 1'b0;
      chk("hs_count", nres, 2);
      chk("hs_first", c0, 5);
      chk("hs_gap", c1 - c0, 6);
      tick();
      tick();

      meas_vld3 = 1'b1;
      meas_ch3 = 2'd3;
      meas3 = W'(1234);
      for (int c = 0; c < 8; c++) begin
         tick();
         chk("oor_vld", duty_vld3, 0);
         chk("oor_rdy", meas_rdy3, 1);
      end
      meas_vld3 = 1'b0;

      for (int n = 0; n < 150; n++) begin
         int ch, r;
         ch = int'($urandom_range(0, NCH - 1));
         r = int'($urandom_range(0, 9));
         if (r == 0) pulse_clr();
         if (r < 3) begin
            cfg_all(ch, int'($urandom_range(0, 16383)) - 8192,
                    int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 127)));
         end else if (r == 3) begin
            cfg(ch, int'($urandom_range(1, 3)),
                int'($urandom_range(0, 1023)));
         end
         run_sample($sformatf("rnd%0d", n), ch,
                    int'($urandom_range(0, 16383)) - 8192, 1'b1, 0);
      end

      cfg_all(1, 300, 64, 0, 0);
      meas_vld = 1'b1;
      meas_ch = 2'd1;
      meas = '0;
      tick();
      meas_vld = 1'b0;
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_vld", duty_vld, 0);
      chk("arst_duty", duty, 0);
      chk("arst_rdy", meas_rdy, 1);
      chk("arst_busy", busy, 0);
      nres = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (duty_vld) nres++;
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (duty_vld) nres++;
      end
      chk("arst_novld", nres, 0);
      model_reset(1'b1);
      cfg_all(1, 100, 64, 0, 0);
      run_sample("post_rst", 1, 0, 1'b0, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
